// File: rtl/l2_cacheline_adaptor_if.sv
// Line-side (L2) and burst-side (physical memory) signals of the cacheline adaptor.
// The adaptor connects through the slave modport, and its driver connects through the master modport.
interface l2_cacheline_adaptor_if #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
);
    logic [s_line-1:0]  line_i;
    logic [31:0]        address_i;
    logic               read_i;
    logic               write_i;
    logic [s_line-1:0]  line_o;
    logic               resp_o;
    logic [s_burst-1:0] burst_i;
    logic               resp_i;
    logic [s_burst-1:0] burst_o;
    logic [31:0]        address_o;
    logic               read_o;
    logic               write_o;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/l2_cacheline_adaptor.sv
// Turns one L2 line request into a burst of s_line/s_burst beats on the memory port.
// Read beats are gathered into a line buffer, and a write line is sent out one beat at a time.
module l2_cacheline_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    l2_cacheline_adaptor_if.slave bus
);
    localparam int s_beats = s_line / s_burst;
    localparam int CNT_W   = $clog2(s_beats);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(s_beats - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [s_line-1:0]  line_q,  line_d;
    logic [s_line-1:0]  wbuf_q,  wbuf_d;
    logic [31:0]        addr_q,  addr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            wbuf_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            wbuf_q  <= wbuf_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        wbuf_d  = wbuf_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                // A write takes priority when both requests are raised together.
                if (bus.write_i) begin
                    state_d = WR;
                    cnt_d   = '0;
                    addr_d  = bus.address_i & 32'hFFFF_FFE0;
                    wbuf_d  = bus.line_i;
                end else if (bus.read_i) begin
                    state_d = RD;
                    cnt_d   = '0;
                    addr_d  = bus.address_i & 32'hFFFF_FFE0;
                end
            end
            RD: begin
                if (bus.resp_i) begin
                    line_d[cnt_q*s_burst +: s_burst] = bus.burst_i;
                    if (cnt_q == LAST) state_d = DONE;
                    else               cnt_d   = cnt_q + 1'b1;
                end
            end
            WR: begin
                if (bus.resp_i) begin
                    if (cnt_q == LAST) state_d = DONE;
                    else               cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.read_o    = (state_q == RD);
        bus.write_o   = (state_q == WR);
        bus.resp_o    = (state_q == DONE);
        bus.line_o    = line_q;
        bus.address_o = addr_q;
        bus.burst_o   = '0;
        if (state_q == WR) bus.burst_o = wbuf_q[cnt_q*s_burst +: s_burst];
    end
endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Directed bench for l2_cacheline_adaptor: reads with and without stalls, writes, request priority,
// back-to-back transactions and reset in the middle of a burst.
module tb_l2_cacheline_adaptor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [63:0] rbeat [4];
    logic [63:0] wexp  [4];

    l2_cacheline_adaptor_if #(.s_line(256), .s_burst(64)) bus ();

    l2_cacheline_adaptor #(.s_line(256), .s_burst(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [6:0] pat, input int npat,
                           input logic [255:0] exp_prev, input int exp_cycles);
        int cyc, k, nb, last;
        logic seen, r;
        bus.read_i    = 1'b1;
        bus.write_i   = 1'b0;
        bus.address_i = addr;
        bus.resp_i    = 1'b0;
        cyc = 1; k = 0; nb = 0; last = 0; seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            cyc++;
            if (bus.resp_o) begin
                seen = 1'b1;
                break;
            end
            if (cyc == 2) chk("rd_addr", bus.address_o, exp_addr);
            if (nb == 0)  chk("rd_line_hold", bus.line_o, exp_prev);
            chk("rd_read_o", bus.read_o, 1'b1);
            chk("rd_write_o", bus.write_o, 1'b0);
            r = (k < npat) ? pat[k] : 1'b1;
            k++;
            bus.resp_i  = r;
            bus.burst_i = r ? rbeat[nb] : 64'hDEAD_BEEF_0BAD_F00D;
            if (r) begin
                nb++;
                last = cyc;
            end
        end
        bus.resp_i  = 1'b0;
        bus.burst_i = '0;
        if (!seen) begin
            chk("rd_timeout", 1'b0, 1'b1);
        end else begin
            chk("rd_resp_after_last", cyc - last, 1);
            chk("rd_line", bus.line_o, {rbeat[3], rbeat[2], rbeat[1], rbeat[0]});
            chk("rd_read_o_done", bus.read_o, 1'b0);
            if (exp_cycles != 0) chk("rd_cycles", cyc, exp_cycles);
        end
        @(negedge clk);
        bus.read_i = 1'b0;
        chk("rd_resp_one_cycle", bus.resp_o, 1'b0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                            input logic [255:0] line, input logic also_read,
                            input logic [6:0] pat, input int npat);
        int cyc, k, nb;
        logic seen, r;
        bus.write_i   = 1'b1;
        bus.read_i    = also_read;
        bus.address_i = addr;
        bus.line_i    = line;
        bus.resp_i    = 1'b0;
        cyc = 1; k = 0; nb = 0; seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            cyc++;
            if (bus.resp_o) begin
                seen = 1'b1;
                break;
            end
            if (cyc == 2) chk("wr_addr", bus.address_o, exp_addr);
            chk("wr_write_o", bus.write_o, 1'b1);
            chk("wr_read_o", bus.read_o, 1'b0);
            chk("wr_burst", bus.burst_o, wexp[nb]);
            r = (k < npat) ? pat[k] : 1'b1;
            k++;
            bus.resp_i = r;
            if (r) nb++;
        end
        bus.resp_i = 1'b0;
        if (!seen) begin
            chk("wr_timeout", 1'b0, 1'b1);
        end else begin
            chk("wr_beats", nb, 4);
            chk("wr_write_o_done", bus.write_o, 1'b0);
            chk("wr_burst_done", bus.burst_o, 64'h0);
            chk("wr_addr_hold", bus.address_o, exp_addr);
        end
        @(negedge clk);
        bus.write_i = 1'b0;
        bus.read_i  = 1'b0;
        chk("wr_resp_one_cycle", bus.resp_o, 1'b0);
    endtask

    initial begin
        bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
        bus.burst_i = '0; bus.resp_i = 1'b0;
        rbeat[0] = {16{4'h1}}; rbeat[1] = {16{4'h2}}; rbeat[2] = {16{4'h3}}; rbeat[3] = {16{4'h4}};
        wexp[0] = 64'hA; wexp[1] = 64'hB; wexp[2] = 64'hC; wexp[3] = 64'hD;

        repeat (2) @(negedge clk);
        chk("rst_read_o", bus.read_o, 1'b0);
        chk("rst_write_o", bus.write_o, 1'b0);
        chk("rst_resp_o", bus.resp_o, 1'b0);
        chk("rst_line_o", bus.line_o, 256'h0);
        chk("rst_burst_o", bus.burst_o, 64'h0);
        chk("rst_address_o", bus.address_o, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_read_o", bus.read_o, 1'b0);
        chk("post_rst_resp_o", bus.resp_o, 1'b0);

        do_read(32'h0000_1234, 32'h0000_1220, 7'b0, 0, 256'h0, 6);
        do_read(32'h0000_5678, 32'h0000_5660, 7'b1011001, 7,
                {rbeat[3], rbeat[2], rbeat[1], rbeat[0]}, 0);

        do_write(32'hFFFF_FFE7, 32'hFFFF_FFE0, {64'hD, 64'hC, 64'hB, 64'hA}, 1'b0, 7'b0, 0);
        do_write(32'h0000_004F, 32'h0000_0040, {64'hD, 64'hC, 64'hB, 64'hA}, 1'b1, 7'b0000101, 3);

        do_write(32'h0000_1000, 32'h0000_1000, {64'hD, 64'hC, 64'hB, 64'hA}, 1'b0, 7'b0, 0);
        rbeat[0] = {16{4'h5}}; rbeat[1] = {16{4'h6}}; rbeat[2] = {16{4'h7}}; rbeat[3] = {16{4'h8}};
        do_read(32'h0000_2011, 32'h0000_2000, 7'b0, 0,
                {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 6);

        // Reset after two read beats have been captured.
        bus.read_i = 1'b1; bus.address_i = 32'h0000_3000;
        @(negedge clk);
        bus.resp_i = 1'b1; bus.burst_i = {16{4'h9}};
        @(negedge clk);
        bus.burst_i = {16{4'hA}};
        @(negedge clk);
        bus.resp_i = 1'b0; bus.read_i = 1'b0; bus.burst_i = '0;
        rst = 1'b0;
        #1;
        chk("mid_rst_read_o", bus.read_o, 1'b0);
        chk("mid_rst_line_o", bus.line_o, 256'h0);
        chk("mid_rst_address_o", bus.address_o, 32'h0);
        chk("mid_rst_resp_o", bus.resp_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("after_rst_read_o", bus.read_o, 1'b0);
            chk("after_rst_resp_o", bus.resp_o, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
